// File: rtl/idct2_1d_seq.sv
// idct2_1d_seq: sequential 1-D inverse DCT-II (4/8/16/32 points), one coefficient column per cycle.
// Optional build macro IDCT_ZERO_SKIP_EN ends accumulation after the last non-zero coefficient.
module idct2_1d_seq #(
    parameter int SHIFT = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [15:0]  X [0:31],
    input  logic        [1:0]   N,
    output logic                out_valid,
    input  logic                out_ready,
    output logic        [511:0] Y
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    localparam logic signed [28:0] PRELOAD = 29'(64'd1 << (SHIFT - 1));

    state_t             state_q, state_d;
    logic        [4:0]  k_q, k_d;
    logic        [1:0]  n_q, n_d;
    logic signed [15:0] x_q [0:31];
    logic signed [15:0] x_d [0:31];
    logic signed [28:0] acc_q [0:31];
    logic signed [28:0] acc_d [0:31];

    logic        [5:0]  size;
    logic        [4:0]  k_last;
    logic        [4:0]  row;
    logic signed [15:0] x_cur;

    assign size      = 6'd32 >> n_q;
    assign row       = k_q << n_q;
    assign x_cur     = x_q[k_q];
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);

`ifdef IDCT_ZERO_SKIP_EN
    logic [4:0] last_q, last_d;
    logic [5:0] size_in;

    assign size_in = 6'd32 >> N;
    assign k_last  = last_q;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && in_valid) begin
            last_d = '0;
            for (int unsigned k = 0; k < 32; k++)
                if (k < 32'(size_in) && X[k] != '0) last_d = 5'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= '0;
        else        last_q <= last_d;
    end
`else
    assign k_last = 5'(size - 6'd1);
`endif

    // VVC 8-bit DCT-II entry T32[r][n]; angle index (2n+1)*r is in units of pi/64, mod 128
    function automatic logic signed [7:0] coef(input logic [4:0] r, input logic [4:0] n);
        logic        [6:0] m;
        logic        [6:0] a;
        logic              neg;
        logic signed [7:0] mag;
        m = 7'({n, 1'b1}) * 7'(r);
        case (m[6:5])
            2'b00:   begin a = m;          neg = 1'b0; end
            2'b01:   begin a = 7'd64 - m;  neg = 1'b1; end
            2'b10:   begin a = m - 7'd64;  neg = 1'b1; end
            default: begin a = 7'd0 - m;   neg = 1'b0; end
        endcase
        case (a)
            7'd0:                mag = 8'sd64;
            7'd1, 7'd2, 7'd3:    mag = 8'sd90;
            7'd4:  mag = 8'sd89; 7'd5:  mag = 8'sd88; 7'd6:  mag = 8'sd87; 7'd7:  mag = 8'sd85;
            7'd8:  mag = 8'sd83; 7'd9:  mag = 8'sd82; 7'd10: mag = 8'sd80; 7'd11: mag = 8'sd78;
            7'd12: mag = 8'sd75; 7'd13: mag = 8'sd73; 7'd14: mag = 8'sd70; 7'd15: mag = 8'sd67;
            7'd16: mag = 8'sd64; 7'd17: mag = 8'sd61; 7'd18: mag = 8'sd57; 7'd19: mag = 8'sd54;
            7'd20: mag = 8'sd50; 7'd21: mag = 8'sd46; 7'd22: mag = 8'sd43; 7'd23: mag = 8'sd38;
            7'd24: mag = 8'sd36; 7'd25: mag = 8'sd31; 7'd26: mag = 8'sd25; 7'd27: mag = 8'sd22;
            7'd28: mag = 8'sd18; 7'd29: mag = 8'sd13; 7'd30: mag = 8'sd9;  7'd31: mag = 8'sd4;
            default:             mag = 8'sd0;
        endcase
        return neg ? -mag : mag;
    endfunction

    always_comb begin
        logic signed [23:0] p;
        p       = '0;
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        x_d     = x_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ACC;
                    k_d     = '0;
                    n_d     = N;
                    x_d     = X;
                    for (int unsigned i = 0; i < 32; i++) acc_d[i] = PRELOAD;
                end
            end
            ACC: begin
                for (int unsigned i = 0; i < 32; i++) begin
                    if (i < 32'(size)) begin
                        p        = 24'(x_cur) * 24'(coef(row, 5'(i)));
                        acc_d[i] = acc_q[i] + 29'(p);
                    end
                end
                if (k_q == k_last) state_d = OUT;
                else               k_d     = k_q + 5'd1;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic signed [28:0] sh;
        sh = '0;
        Y  = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < 32'(size)) begin
                sh = acc_q[i] >>> SHIFT;
                if (sh > 29'sd32767)       Y[16*i +: 16] = 16'h7fff;
                else if (sh < -29'sd32768) Y[16*i +: 16] = 16'h8000;
                else                       Y[16*i +: 16] = sh[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                x_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_idct2_1d_seq.sv
// Self-checking bench for idct2_1d_seq: directed vectors plus a behavioural reference model.
module tb_idct2_1d_seq;
    localparam int SH = 7;
`ifdef IDCT_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam int MAG [0:32] = '{64, 90, 90, 90, 89, 88, 87, 85, 83, 82, 80, 78, 75, 73, 70, 67,
                                  64, 61, 57, 54, 50, 46, 43, 38, 36, 31, 25, 22, 18, 13, 9, 4, 0};

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b1;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b1;
    logic        [1:0]  nsel      = 2'd0;
    logic signed [15:0] xs [0:31];
    logic               in_ready;
    logic               out_valid;
    logic        [511:0] y;

    int checks = 0;
    int errors = 0;

    int           m_phase = 0;   // 0 idle, 1 accumulating, 2 presenting
    int           m_cnt   = 0;
    logic [511:0] m_y     = '0;

    always #5 clk = ~clk;

    idct2_1d_seq #(.SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .X(xs), .N(nsel),
        .out_valid(out_valid), .out_ready(out_ready), .Y(y)
    );

    function automatic int tcoef(input int r, input int n);
        int m, s;
        m = ((2 * n + 1) * r) % 128;
        s = 1;
        if (m > 64) m = 128 - m;
        if (m > 32) begin m = 64 - m; s = -1; end
        return s * MAG[m];
    endfunction

    function automatic logic [511:0] golden(input logic [1:0] nc, input logic signed [15:0] v [0:31]);
        logic [511:0] r;
        longint s;
        int sz;
        r  = '0;
        sz = 32 >> nc;
        for (int n = 0; n < sz; n++) begin
            s = 2 ** (SH - 1);
            for (int k = 0; k < sz; k++) s += longint'(tcoef(k * (32 / sz), n)) * longint'(v[k]);
            s = s >>> SH;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            r[16*n +: 16] = 16'(s);
        end
        return r;
    endfunction

    function automatic int lat_of(input logic [1:0] nc, input logic signed [15:0] v [0:31]);
        int sz, last;
        sz   = 32 >> nc;
        last = 0;
        if (!SKIP) return sz;
        for (int k = 0; k < sz; k++) if (v[k] != 0) last = k;
        return last + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_y     <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_y     <= golden(nsel, xs);
                    m_cnt   <= lat_of(nsel, xs);
                    m_phase <= 1;
                end
                1: if (m_cnt <= 1) m_phase <= 2; else m_cnt <= m_cnt - 1;
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (in_ready !== (m_phase == 0) || out_valid !== (m_phase == 2)) begin
                errors++;
                $display("FAIL handshake: in_ready=%0b out_valid=%0b required %0b %0b",
                         in_ready, out_valid, m_phase == 0, m_phase == 2);
            end
            if (m_phase != 1) begin
                checks++;
                if (y !== m_y) begin
                    errors++;
                    $display("FAIL y_model: got %h required %h", y, m_y);
                end
            end
        end
    end

    task automatic check_int(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic int lane(input int n);
        return int'($signed(y[16*n +: 16]));
    endfunction

    task automatic clear_x();
        for (int k = 0; k < 32; k++) xs[k] = '0;
    endtask

    task automatic send(input logic [1:0] nc, output int lat);
        int to;
        @(negedge clk);
        nsel = nc;
        in_valid = 1'b1;
        to = 0;
        while (!in_ready && to < 500) begin @(negedge clk); to++; end
        if (to >= 500) check_int("accept_timeout", to, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic finish_out(input string name);
        @(posedge clk);
        @(negedge clk);
        check_int(name, longint'(in_ready), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, to, sz, nz;
        logic [1:0] nc;
        logic [511:0] yc, tmp;

        clear_x();
        #1 rst_n = 1'b0;
        #1;
        check_int("rst_in_ready", longint'(in_ready), 1);
        check_int("rst_out_valid", longint'(out_valid), 0);
        check_vec("rst_y", y, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check_int("tcoef_r1n0", tcoef(1, 0), 90);
        check_int("tcoef_r31n0", tcoef(31, 0), 4);
        check_int("tcoef_r16n1", tcoef(16, 1), -64);
        check_int("tcoef_r4n7", tcoef(4, 7), -89);
        xs[0] = 16'sd32767; xs[1] = 16'sd32767;
        tmp = golden(2'd3, xs);
        check_int("gold_sat0", longint'($signed(tmp[15:0])), 32767);
        check_int("gold_sat3", longint'($signed(tmp[63:48])), -4864);

        // 4-point DC
        clear_x();
        xs[0] = 16'sd64;
        send(2'd3, lat);
        check_int("dc4_latency", lat, SKIP ? 1 : 4);
        for (int n = 0; n < 4; n++) check_int($sformatf("dc4_lane%0d", n), lane(n), 32);
        tmp = y; tmp[63:0] = '0;
        check_vec("dc4_upper_zero", tmp, '0);
        finish_out("dc4_idle_after");

        // 32-point DC
        clear_x();
        xs[0] = 16'sd128;
        send(2'd0, lat);
        check_int("dc32_latency", lat, SKIP ? 1 : 32);
        for (int n = 0; n < 32; n++) check_int($sformatf("dc32_lane%0d", n), lane(n), 64);
        finish_out("dc32_idle_after");

        // saturation and floor
        clear_x();
        xs[0] = 16'sd32767; xs[1] = 16'sd32767;
        send(2'd3, lat);
        check_int("sat_latency", lat, SKIP ? 2 : 4);
        check_int("sat_lane0", lane(0), 32767);
        check_int("sat_lane1", lane(1), 25599);
        check_int("sat_lane2", lane(2), 7168);
        check_int("sat_lane3", lane(3), -4864);
        finish_out("sat_idle_after");

        // backpressure
        clear_x();
        xs[0] = 16'sd64; xs[1] = -16'sd100;
        out_ready = 1'b0;
        send(2'd2, lat);
        check_int("bp_latency", lat, SKIP ? 2 : 8);
        check_int("bp_lane0", lane(0), -38);
        check_int("bp_lane7", lane(7), 102);
        yc = y;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            xs[0] = 16'(i * 7 + 1);
            check_int("bp_out_valid", longint'(out_valid), 1);
            check_int("bp_in_ready", longint'(in_ready), 0);
            check_vec("bp_y_hold", y, yc);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_int("bp_release_in_ready", longint'(in_ready), 1);
        check_int("bp_release_out_valid", longint'(out_valid), 0);

        // reset in the middle of a 32-point accumulation
        for (int k = 0; k < 32; k++) xs[k] = 16'(k * 100 - 1000);
        @(negedge clk);
        nsel = 2'd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_int("midrst_out_valid", longint'(out_valid), 0);
        check_int("midrst_in_ready", longint'(in_ready), 1);
        check_vec("midrst_y", y, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        clear_x();
        xs[0] = 16'sd64;
        send(2'd2, lat);
        check_int("postrst_latency", lat, SKIP ? 1 : 8);
        for (int n = 0; n < 8; n++) check_int($sformatf("postrst_lane%0d", n), lane(n), 32);
        tmp = y; tmp[127:0] = '0;
        check_vec("postrst_upper_zero", tmp, '0);
        finish_out("postrst_idle_after");

        // random regression with random downstream readiness
        for (int it = 0; it < 1000; it++) begin
            nc = 2'($urandom_range(0, 3));
            sz = 32 >> nc;
            nz = int'($urandom_range(0, sz));
            for (int k = 0; k < 32; k++) begin
                if (k >= sz)                     xs[k] = 16'($urandom);
                else if (k >= nz)                xs[k] = '0;
                else if ($urandom_range(0, 3) == 0) xs[k] = 16'($urandom);
                else                             xs[k] = 16'(int'($urandom_range(0, 400)) - 200);
            end
            @(negedge clk);
            nsel = nc;
            in_valid = 1'b1;
            out_ready = ($urandom_range(0, 3) != 0);
            to = 0;
            while (!in_ready && to < 500) begin
                @(negedge clk);
                out_ready = ($urandom_range(0, 3) != 0);
                to++;
            end
            if (to >= 500) check_int("rand_accept_timeout", to, 0);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        to = 0;
        while (!in_ready && to < 100) begin @(negedge clk); to++; end
        if (to >= 100) check_int("drain_timeout", to, 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/idct2_1d_seq.md
# idct2_1d_seq

Sequential 1-D inverse DCT-II engine for VVC residual reconstruction. It is the inverse counterpart of the combinational forward DCT-II datapath and covers the same sizes and size encoding (4/8/16/32 points). The engine accepts one coefficient vector per transaction over a valid/ready handshake. It accumulates one coefficient column per cycle into 32 parallel accumulators, then presents a rounded, shifted, clipped residual vector over a second valid/ready handshake.

## Interface
- SHIFT, 7, output right-shift applied after accumulation (first inverse stage); rounding offset is 1<<(SHIFT-1); legal range 1..12
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous and active-low
- in_valid  in  1  coefficient vector valid
- in_ready  out  1  engine idle, vector accepted on in_valid & in_ready edge
- X  in  16 x [0:31] signed  coefficients X[k]; only k < size used
- N  in  2  size select, sampled with X: 0→32, 1→16, 2→8, 3→4
- out_valid  out  1  residual vector valid
- out_ready  in  1  downstream accepts Y on out_valid & out_ready edge
- Y  out  512  packed residuals, sample n at Y[16n+15:16n], signed

## Operation
- States: IDLE, ACC, OUT. in_ready = (state==IDLE); out_valid = (state==OUT).
- IDLE: accept edge latches N and X[0:31]. Each accumulator acc[n] is preloaded with 1<<(SHIFT-1). k←0. Next state is ACC.
- ACC, one cycle per k: acc[n] += T_size[k][n] * X[k] for all n < size; acc[n] for n ≥ size stays at its preload value.
- T_size[k][n] = T32[k*(32/size)][n], where T32 is the standard VVC 8-bit DCT-II matrix (row 0 all 64). ROM is combinational, indexed by k and size.
- ACC runs L cycles; after the cycle with k = L-1, next state is OUT. Without the macro, L = size.
- Widths: product 16x8 gives 24 bits signed; acc is 29 bits signed, which holds the worst case of 32 terms without overflow.
- Y lane n = clip16(acc[n] >>> SHIFT) for n < size, where >>> is arithmetic (floor). Lanes n ≥ size are forced to 0. Y is combinational from the accumulators and stable throughout OUT.
- clip16 saturates to [-32768, 32767].
- OUT: held until out_valid & out_ready; then next state is IDLE. Accumulators are not cleared on exit.
- in_valid outside IDLE is ignored; the engine never accepts a new vector in the same cycle as an out handshake.
- Async reset, at any state including mid-ACC: state = IDLE, out_valid = 0, in_ready = 1, accumulators = 0 (so Y = 0), k = 0, latched N = 0. In-flight data is discarded.

## Timing
- Accept at edge E0, then out_valid high after edge E0+L.
- Earliest out handshake is edge E0+L+1; earliest next accept is edge E0+L+2.
- Without the macro, throughput is size+2 cycles per vector at full downstream readiness.
- Output stall of any length: Y and out_valid are held; in_ready stays 0.
- Reset values: in_ready 1, out_valid 0, Y 0.

## Configuration
- IDCT_ZERO_SKIP_EN defined:
  - At the accept edge, the engine registers last = the highest k < size with X[k] ≠ 0.
  - L = last+1, or L = 1 if all coefficients are zero.
  - Skipped columns contribute zero, so results are bit-identical to the non-skip build; only latency changes.
- Undefined: L = size always. No zero-detect logic is built.

## Test plan
- 4-point DC:
  - Stimulus: N=3, X={64,0,0,0}.
  - Response: Y[0..3]=32, Y[4..31]=0. out_valid 4 cycles after accept (1 cycle with IDCT_ZERO_SKIP_EN).
- 32-point DC:
  - Stimulus: N=0, X[0]=128, all others 0.
  - Response: all 32 lanes = 64. Latency 32 (1 with skip).
- Saturation and floor:
  - Stimulus: N=3, X={32767,32767,0,0}.
  - Response: Y[0]=32767 (clipped from 37631), Y[1]=25599, Y[2]=7168, Y[3]=-4864.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles during OUT, pulsing in_valid.
  - Response: Y and out_valid stable, in_ready=0, no vector accepted. Release gives one handshake, then in_ready=1 on the next cycle.
- Reset mid-ACC:
  - Stimulus: drive rst_n=0 at k=10 of a 32-point transaction.
  - Response: out_valid=0, in_ready=1, Y=0 immediately. The following 8-point transaction with X[0]=64 yields Y[0..7]=32.
- Random regression:
  - Stimulus: 1000 random vectors, random N, random out_ready.
  - Response: every lane matches the golden model clip16((sum T·X + 2^(SHIFT-1)) >>> SHIFT). Skip and non-skip builds give identical Y.
